// File: rtl/l2_cache_write.sv
// ---------------------------------------------------------------------------
// l2_cache_write
//
// L2 pipeline write stage. It sits between the L2 read stage (rd_*) and the
// L2 response stage (wr_*). Each cycle it:
//   - picks the source line: the memory fill (rd_sm_data) when
//     rd_has_sm_data is set, otherwise the SRAM read (rd_cache_mem_result);
//   - merges store data into that line under the 64-bit byte mask;
//   - drives the L2 data SRAM write port (enable / way / line address);
//   - tracks per-strand load_sync reservations and reports whether a
//     store_sync succeeded.
// Every wr_* output is registered. Latency is one cycle and there is no stall.
//
// Optional feature (macro L2_STORE_SYNC_EN):
//   defined   - an 8-entry reservation table, indexed by core*4+strand, backs
//               LOAD_SYNC / STORE_SYNC.
//   undefined - no table. STORE_SYNC never succeeds and never writes, and
//               LOAD_SYNC behaves exactly like LOAD.
//
// Ports:
//   clk, reset_n             clock and asynchronous active-low reset
//   rd_l2req_*               request from the read stage (valid, core, unit,
//                            strand, op, L1 way, line address, store data,
//                            byte mask)
//   rd_hit_l2_way            L2 way that hit or is being filled
//   rd_cache_hit             L2 tag hit
//   rd_has_sm_data           the line comes from a memory fill
//   rd_sm_data               fill line
//   rd_cache_mem_result      line read from the SRAM
//   rd_l1_has_line_core*,
//   rd_dir_l1_way_core*      L1 directory state, passed through
//   wr_l2req_*               registered copy of the request fields
//   wr_data                  final line contents
//   wr_l1_has_line_core*,
//   wr_dir_l1_way_core*      registered directory state
//   wr_cache_hit,
//   wr_has_sm_data           registered hit and fill flags
//   wr_store_sync_success    the store_sync found a valid matching reservation
//   wr_update_l2_data/way/address
//                            SRAM data write port
// ---------------------------------------------------------------------------
module l2_cache_write #(
    parameter int ADDR_WIDTH = 26
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  rd_l2req_valid,
    input  logic [1:0]            rd_l2req_core,
    input  logic [1:0]            rd_l2req_unit,
    input  logic [1:0]            rd_l2req_strand,
    input  logic [2:0]            rd_l2req_op,
    input  logic [1:0]            rd_l2req_way,
    input  logic [ADDR_WIDTH-1:0] rd_l2req_address,
    input  logic [511:0]          rd_l2req_data,
    input  logic [63:0]           rd_l2req_mask,
    input  logic [1:0]            rd_hit_l2_way,
    input  logic                  rd_cache_hit,
    input  logic                  rd_has_sm_data,
    input  logic [511:0]          rd_sm_data,
    input  logic [511:0]          rd_cache_mem_result,
    input  logic                  rd_l1_has_line_core0,
    input  logic [1:0]            rd_dir_l1_way_core0,
    input  logic                  rd_l1_has_line_core1,
    input  logic [1:0]            rd_dir_l1_way_core1,

    output logic                  wr_l2req_valid,
    output logic [1:0]            wr_l2req_core,
    output logic [1:0]            wr_l2req_unit,
    output logic [1:0]            wr_l2req_strand,
    output logic [2:0]            wr_l2req_op,
    output logic [1:0]            wr_l2req_way,
    output logic [511:0]          wr_data,
    output logic                  wr_l1_has_line_core0,
    output logic [1:0]            wr_dir_l1_way_core0,
    output logic                  wr_l1_has_line_core1,
    output logic [1:0]            wr_dir_l1_way_core1,
    output logic                  wr_cache_hit,
    output logic                  wr_has_sm_data,
    output logic                  wr_store_sync_success,
    output logic                  wr_update_l2_data,
    output logic [1:0]            wr_update_l2_way,
    output logic [ADDR_WIDTH-1:0] wr_update_l2_address
);

    localparam logic [2:0] OP_LOAD       = 3'd0;
    localparam logic [2:0] OP_STORE      = 3'd1;
    localparam logic [2:0] OP_FLUSH      = 3'd2;
    localparam logic [2:0] OP_INVALIDATE = 3'd3;
    localparam logic [2:0] OP_LOAD_SYNC  = 3'd4;
    localparam logic [2:0] OP_STORE_SYNC = 3'd5;

    // Mask bit j enables bits [8j+7:8j]; this places mask bit 63 on bits
    // 511:504, i.e. byte 0 of the line in its big-endian numbering.
    function automatic logic [511:0] merge_line(
        input logic [511:0] old_line,
        input logic [511:0] store_data,
        input logic [63:0]  mask
    );
        logic [511:0] merged;
        merged = old_line;
        for (int j = 0; j < 64; j++) begin
            if (mask[j])
                merged[8*j +: 8] = store_data[8*j +: 8];
        end
        return merged;
    endfunction

    // ---- stage p0: combinational decode of the incoming request ----
    logic                  serviced_p0;
    logic [511:0]          old_line_p0;
    logic                  sync_ok_p0;
    logic                  commit_store_p0;
    logic                  write_en_p0;
    logic [511:0]          line_p0;

    // A request is serviced only when the line is actually available: a tag
    // hit or a fill arriving from memory. Misses still flow down the pipe.
    assign serviced_p0     = rd_l2req_valid && (rd_cache_hit || rd_has_sm_data);
    assign old_line_p0     = rd_has_sm_data ? rd_sm_data : rd_cache_mem_result;
    assign commit_store_p0 = serviced_p0 &&
                             ((rd_l2req_op == OP_STORE) || sync_ok_p0);
    // A fill is written even for non-store ops (FLUSH, INVALIDATE included)
    // because the line is being installed in the SRAM.
    assign write_en_p0     = serviced_p0 && (rd_has_sm_data || commit_store_p0);
    assign line_p0         = commit_store_p0
                           ? merge_line(old_line_p0, rd_l2req_data, rd_l2req_mask)
                           : old_line_p0;

`ifdef L2_STORE_SYNC_EN
    // Reservation table: one entry per (core, strand) pair, index core*4+strand.
    // Only the valid bits are reset; an address is meaningful only while its
    // valid bit is set.
    logic [7:0]            resv_valid;
    logic [ADDR_WIDTH-1:0] resv_addr [8];
    logic [2:0]            resv_idx_p0;
    logic                  resv_idx_ok_p0;
    logic [7:0]            resv_match_p0;
    logic                  resv_set_p0;

    // Only cores 0 and 1 own reservation entries; any other core id never
    // reserves and never succeeds rather than aliasing onto another entry.
    assign resv_idx_ok_p0 = (rd_l2req_core[1] == 1'b0);
    assign resv_idx_p0    = {rd_l2req_core[0], rd_l2req_strand};
    assign resv_set_p0    = serviced_p0 && (rd_l2req_op == OP_LOAD_SYNC) &&
                            resv_idx_ok_p0;

    always_comb begin
        resv_match_p0 = '0;
        for (int i = 0; i < 8; i++) begin
            resv_match_p0[i] = resv_valid[i] &&
                               (resv_addr[i] == rd_l2req_address);
        end
    end

    assign sync_ok_p0 = serviced_p0 && (rd_l2req_op == OP_STORE_SYNC) &&
                        resv_idx_ok_p0 && resv_match_p0[resv_idx_p0];

    // Any committed store to a line kills every reservation on that line,
    // including the issuer's own, so a repeated store_sync must fail.
    // LOAD_SYNC and a committed store are different ops and cannot coincide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resv_valid <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (commit_store_p0 && resv_match_p0[i])
                    resv_valid[i] <= 1'b0;
            end
            if (resv_set_p0)
                resv_valid[resv_idx_p0] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (resv_set_p0)
            resv_addr[resv_idx_p0] <= rd_l2req_address;
    end
`else
    // Without the table no store_sync can succeed, and LOAD_SYNC leaves no
    // trace, which makes it indistinguishable from LOAD.
    assign sync_ok_p0 = 1'b0;
`endif

    // ---- stage p1: registered outputs to the response stage ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_l2req_valid        <= 1'b0;
            wr_l2req_core         <= '0;
            wr_l2req_unit         <= '0;
            wr_l2req_strand       <= '0;
            wr_l2req_op           <= '0;
            wr_l2req_way          <= '0;
            wr_data               <= '0;
            wr_l1_has_line_core0  <= 1'b0;
            wr_dir_l1_way_core0   <= '0;
            wr_l1_has_line_core1  <= 1'b0;
            wr_dir_l1_way_core1   <= '0;
            wr_cache_hit          <= 1'b0;
            wr_has_sm_data        <= 1'b0;
            wr_store_sync_success <= 1'b0;
            wr_update_l2_data     <= 1'b0;
            wr_update_l2_way      <= '0;
            wr_update_l2_address  <= '0;
        end else begin
            wr_l2req_valid        <= rd_l2req_valid;
            wr_l2req_core         <= rd_l2req_core;
            wr_l2req_unit         <= rd_l2req_unit;
            wr_l2req_strand       <= rd_l2req_strand;
            wr_l2req_op           <= rd_l2req_op;
            wr_l2req_way          <= rd_l2req_way;
            wr_data               <= line_p0;
            wr_l1_has_line_core0  <= rd_l1_has_line_core0;
            wr_dir_l1_way_core0   <= rd_dir_l1_way_core0;
            wr_l1_has_line_core1  <= rd_l1_has_line_core1;
            wr_dir_l1_way_core1   <= rd_dir_l1_way_core1;
            wr_cache_hit          <= rd_cache_hit;
            wr_has_sm_data        <= rd_has_sm_data;
            wr_store_sync_success <= sync_ok_p0;
            wr_update_l2_data     <= write_en_p0;
            wr_update_l2_way      <= rd_hit_l2_way;
            wr_update_l2_address  <= rd_l2req_address;
        end
    end

endmodule

// File: tb/tb_l2_cache_write.sv
// ---------------------------------------------------------------------------
// tb_l2_cache_write
//
// Directed testbench for l2_cache_write. Each scenario task drives requests
// and compares the registered wr_* outputs against hand-computed values.
// Expectations for the reservation scenarios follow the L2_STORE_SYNC_EN
// build setting.
// ---------------------------------------------------------------------------
module tb_l2_cache_write;

    localparam int AW = 26;

    localparam logic [2:0] OP_LOAD       = 3'd0;
    localparam logic [2:0] OP_STORE      = 3'd1;
    localparam logic [2:0] OP_FLUSH      = 3'd2;
    localparam logic [2:0] OP_LOAD_SYNC  = 3'd4;
    localparam logic [2:0] OP_STORE_SYNC = 3'd5;

`ifdef L2_STORE_SYNC_EN
    localparam logic SYNC_EN = 1'b1;
`else
    localparam logic SYNC_EN = 1'b0;
`endif

    logic          clk;
    logic          reset_n;
    logic          rd_l2req_valid;
    logic [1:0]    rd_l2req_core;
    logic [1:0]    rd_l2req_unit;
    logic [1:0]    rd_l2req_strand;
    logic [2:0]    rd_l2req_op;
    logic [1:0]    rd_l2req_way;
    logic [AW-1:0] rd_l2req_address;
    logic [511:0]  rd_l2req_data;
    logic [63:0]   rd_l2req_mask;
    logic [1:0]    rd_hit_l2_way;
    logic          rd_cache_hit;
    logic          rd_has_sm_data;
    logic [511:0]  rd_sm_data;
    logic [511:0]  rd_cache_mem_result;
    logic          rd_l1_has_line_core0;
    logic [1:0]    rd_dir_l1_way_core0;
    logic          rd_l1_has_line_core1;
    logic [1:0]    rd_dir_l1_way_core1;

    logic          wr_l2req_valid;
    logic [1:0]    wr_l2req_core;
    logic [1:0]    wr_l2req_unit;
    logic [1:0]    wr_l2req_strand;
    logic [2:0]    wr_l2req_op;
    logic [1:0]    wr_l2req_way;
    logic [511:0]  wr_data;
    logic          wr_l1_has_line_core0;
    logic [1:0]    wr_dir_l1_way_core0;
    logic          wr_l1_has_line_core1;
    logic [1:0]    wr_dir_l1_way_core1;
    logic          wr_cache_hit;
    logic          wr_has_sm_data;
    logic          wr_store_sync_success;
    logic          wr_update_l2_data;
    logic [1:0]    wr_update_l2_way;
    logic [AW-1:0] wr_update_l2_address;

    int total = 0;
    int bad   = 0;

    l2_cache_write #(.ADDR_WIDTH(AW)) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .rd_l2req_valid        (rd_l2req_valid),
        .rd_l2req_core         (rd_l2req_core),
        .rd_l2req_unit         (rd_l2req_unit),
        .rd_l2req_strand       (rd_l2req_strand),
        .rd_l2req_op           (rd_l2req_op),
        .rd_l2req_way          (rd_l2req_way),
        .rd_l2req_address      (rd_l2req_address),
        .rd_l2req_data         (rd_l2req_data),
        .rd_l2req_mask         (rd_l2req_mask),
        .rd_hit_l2_way         (rd_hit_l2_way),
        .rd_cache_hit          (rd_cache_hit),
        .rd_has_sm_data        (rd_has_sm_data),
        .rd_sm_data            (rd_sm_data),
        .rd_cache_mem_result   (rd_cache_mem_result),
        .rd_l1_has_line_core0  (rd_l1_has_line_core0),
        .rd_dir_l1_way_core0   (rd_dir_l1_way_core0),
        .rd_l1_has_line_core1  (rd_l1_has_line_core1),
        .rd_dir_l1_way_core1   (rd_dir_l1_way_core1),
        .wr_l2req_valid        (wr_l2req_valid),
        .wr_l2req_core         (wr_l2req_core),
        .wr_l2req_unit         (wr_l2req_unit),
        .wr_l2req_strand       (wr_l2req_strand),
        .wr_l2req_op           (wr_l2req_op),
        .wr_l2req_way          (wr_l2req_way),
        .wr_data               (wr_data),
        .wr_l1_has_line_core0  (wr_l1_has_line_core0),
        .wr_dir_l1_way_core0   (wr_dir_l1_way_core0),
        .wr_l1_has_line_core1  (wr_l1_has_line_core1),
        .wr_dir_l1_way_core1   (wr_dir_l1_way_core1),
        .wr_cache_hit          (wr_cache_hit),
        .wr_has_sm_data        (wr_has_sm_data),
        .wr_store_sync_success (wr_store_sync_success),
        .wr_update_l2_data     (wr_update_l2_data),
        .wr_update_l2_way      (wr_update_l2_way),
        .wr_update_l2_address  (wr_update_l2_address)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request on the rd_* side. Directory fields and unit are
    // fixed to recognisable values so the pass-through can be checked.
    task automatic drive(input logic v, input logic [1:0] core,
                         input logic [1:0] strand, input logic [2:0] op,
                         input logic [AW-1:0] addr, input logic hit,
                         input logic sm, input logic [511:0] smd,
                         input logic [511:0] memd, input logic [511:0] data,
                         input logic [63:0] mask, input logic [1:0] way);
        rd_l2req_valid       = v;
        rd_l2req_core        = core;
        rd_l2req_unit        = 2'd1;
        rd_l2req_strand      = strand;
        rd_l2req_op          = op;
        rd_l2req_way         = 2'd2;
        rd_l2req_address     = addr;
        rd_l2req_data        = data;
        rd_l2req_mask        = mask;
        rd_hit_l2_way        = way;
        rd_cache_hit         = hit;
        rd_has_sm_data       = sm;
        rd_sm_data           = smd;
        rd_cache_mem_result  = memd;
        rd_l1_has_line_core0 = 1'b1;
        rd_dir_l1_way_core0  = 2'd3;
        rd_l1_has_line_core1 = 1'b0;
        rd_dir_l1_way_core1  = 2'd1;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 2'd0, OP_LOAD, '0, 1'b0, 1'b0, '0, '0, '0, '0, 2'd0);
    endtask

    task automatic test_reset();
        logic [511:0] rnd;
        reset_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 16; k++) rnd[32*k +: 32] = $urandom;
            drive(1'b1, 2'($urandom), 2'($urandom), 3'($urandom_range(0, 5)),
                  AW'($urandom), 1'b1, 1'($urandom), rnd, ~rnd, rnd,
                  {$urandom, $urandom}, 2'($urandom));
            step();
        end
        total++;
        if ({wr_l2req_valid, wr_l2req_core, wr_l2req_unit, wr_l2req_strand,
             wr_l2req_op, wr_l2req_way} !== 12'd0) begin
            bad++;
            $display("FAIL reset_req got=%h exp=0", {wr_l2req_valid, wr_l2req_core,
                     wr_l2req_unit, wr_l2req_strand, wr_l2req_op, wr_l2req_way});
        end
        total++;
        if (wr_data !== 512'd0) begin
            bad++; $display("FAIL reset_data got=%h exp=0", wr_data);
        end
        total++;
        if ({wr_l1_has_line_core0, wr_dir_l1_way_core0, wr_l1_has_line_core1,
             wr_dir_l1_way_core1, wr_cache_hit, wr_has_sm_data,
             wr_store_sync_success, wr_update_l2_data, wr_update_l2_way,
             wr_update_l2_address} !== '0) begin
            bad++; $display("FAIL reset_ctrl got nonzero exp=0");
        end
        // Release away from the clock edge with a valid LOAD waiting.
        drive(1'b1, 2'd1, 2'd3, OP_LOAD, 26'h155, 1'b1, 1'b0, '0,
              {64{8'h3C}}, '0, '0, 2'd1);
        reset_n = 1'b1;
        #2;
        total++;
        if (wr_l2req_valid !== 1'b0) begin
            bad++; $display("FAIL release_early got=%b exp=0", wr_l2req_valid);
        end
        step();
        total++;
        if ({wr_l2req_valid, wr_l2req_core, wr_l2req_strand, wr_l2req_op,
             wr_update_l2_address} !== {1'b1, 2'd1, 2'd3, OP_LOAD, 26'h155}) begin
            bad++;
            $display("FAIL first_req got=%b/%0d/%0d/%0d/%h exp=1/1/3/0/155",
                     wr_l2req_valid, wr_l2req_core, wr_l2req_strand,
                     wr_l2req_op, wr_update_l2_address);
        end
        total++;
        if ({wr_data, wr_update_l2_data} !== {{64{8'h3C}}, 1'b0}) begin
            bad++; $display("FAIL first_data got upd=%b data=%h exp upd=0 data=3c..",
                            wr_update_l2_data, wr_data);
        end
    endtask

    task automatic test_passthrough();
        total++;
        if ({wr_l2req_unit, wr_l2req_way, wr_l1_has_line_core0, wr_dir_l1_way_core0,
             wr_l1_has_line_core1, wr_dir_l1_way_core1, wr_cache_hit,
             wr_has_sm_data} !== {2'd1, 2'd2, 1'b1, 2'd3, 1'b0, 2'd1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL passthrough got=%b exp=%b",
                     {wr_l2req_unit, wr_l2req_way, wr_l1_has_line_core0,
                      wr_dir_l1_way_core0, wr_l1_has_line_core1,
                      wr_dir_l1_way_core1, wr_cache_hit, wr_has_sm_data},
                     {2'd1, 2'd2, 1'b1, 2'd3, 1'b0, 2'd1, 1'b1, 1'b0});
        end
    endtask

    task automatic test_store_merge();
        logic [511:0] exp;
        drive(1'b1, 2'd0, 2'd1, OP_STORE, 26'h10, 1'b1, 1'b0, '0, '0,
              {64{8'hFF}}, 64'hF000000000000001, 2'd2);
        step();
        exp = {32'hFFFFFFFF, 472'd0, 8'hFF};
        total++;
        if (wr_data !== exp) begin
            bad++; $display("FAIL store_mask_ends got=%h exp=%h", wr_data, exp);
        end
        total++;
        if ({wr_update_l2_data, wr_update_l2_way, wr_update_l2_address,
             wr_store_sync_success} !== {1'b1, 2'd2, 26'h10, 1'b0}) begin
            bad++; $display("FAIL store_write got upd=%b way=%0d addr=%h ss=%b exp 1/2/10/0",
                            wr_update_l2_data, wr_update_l2_way,
                            wr_update_l2_address, wr_store_sync_success);
        end
        // Merge into a non-zero old line: mask bits 15:8 replace bits 127:64.
        drive(1'b1, 2'd0, 2'd1, OP_STORE, 26'h11, 1'b1, 1'b0, '0, {64{8'h11}},
              {64{8'h22}}, 64'h000000000000FF00, 2'd0);
        step();
        exp = {{48{8'h11}}, {8{8'h22}}, {8{8'h11}}};
        total++;
        if (wr_data !== exp) begin
            bad++; $display("FAIL store_mid_merge got=%h exp=%h", wr_data, exp);
        end
        // Zero mask: line unchanged but the SRAM write still fires.
        drive(1'b1, 2'd1, 2'd0, OP_STORE, 26'h12, 1'b1, 1'b0, '0, {64{8'h77}},
              {64{8'h99}}, 64'd0, 2'd3);
        step();
        total++;
        if ({wr_data, wr_update_l2_data} !== {{64{8'h77}}, 1'b1}) begin
            bad++; $display("FAIL store_zero_mask got upd=%b data=%h exp upd=1 data=77..",
                            wr_update_l2_data, wr_data);
        end
    endtask

    task automatic test_fill();
        // LOAD miss satisfied by a fill: fill line wins over the SRAM read.
        drive(1'b1, 2'd0, 2'd2, OP_LOAD, 26'h2A, 1'b0, 1'b1, {64{8'hA5}},
              {64{8'h5A}}, {64{8'hFF}}, {64{1'b1}}, 2'd3);
        step();
        total++;
        if ({wr_data, wr_update_l2_data, wr_update_l2_way, wr_has_sm_data,
             wr_cache_hit} !== {{64{8'hA5}}, 1'b1, 2'd3, 1'b1, 1'b0}) begin
            bad++; $display("FAIL fill got upd=%b way=%0d data=%h exp upd=1 way=3 data=a5..",
                            wr_update_l2_data, wr_update_l2_way, wr_data);
        end
        // STORE into a fill: merge is applied on top of the fill line.
        drive(1'b1, 2'd0, 2'd2, OP_STORE, 26'h2B, 1'b0, 1'b1, {64{8'hA5}},
              {64{8'h5A}}, {64{8'h00}}, 64'h8000000000000000, 2'd1);
        step();
        total++;
        if ({wr_data, wr_update_l2_data} !== {8'h00, {63{8'hA5}}, 1'b1}) begin
            bad++; $display("FAIL fill_store got upd=%b data=%h", wr_update_l2_data, wr_data);
        end
    endtask

    task automatic test_miss_and_flush();
        // STORE miss with no fill: passes through valid, no write, no merge.
        drive(1'b1, 2'd0, 2'd0, OP_STORE, 26'h3F, 1'b0, 1'b0, {64{8'hA5}},
              {64{8'h44}}, {64{8'hEE}}, {64{1'b1}}, 2'd1);
        step();
        total++;
        if ({wr_l2req_valid, wr_update_l2_data, wr_data} !== {1'b1, 1'b0, {64{8'h44}}}) begin
            bad++; $display("FAIL miss got vld=%b upd=%b data=%h exp 1/0/44..",
                            wr_l2req_valid, wr_update_l2_data, wr_data);
        end
        // FLUSH hit without fill: pass-through only.
        drive(1'b1, 2'd1, 2'd1, OP_FLUSH, 26'h40, 1'b1, 1'b0, '0, {64{8'h66}},
              {64{8'hEE}}, {64{1'b1}}, 2'd2);
        step();
        total++;
        if ({wr_update_l2_data, wr_l2req_op, wr_data} !== {1'b0, OP_FLUSH, {64{8'h66}}}) begin
            bad++; $display("FAIL flush got upd=%b op=%0d data=%h exp 0/2/66..",
                            wr_update_l2_data, wr_l2req_op, wr_data);
        end
        // Invalid request with hit asserted: nothing is serviced.
        drive(1'b0, 2'd0, 2'd0, OP_STORE, 26'h41, 1'b1, 1'b0, '0, {64{8'h12}},
              {64{8'hEE}}, {64{1'b1}}, 2'd0);
        step();
        total++;
        if ({wr_l2req_valid, wr_update_l2_data, wr_data} !== {1'b0, 1'b0, {64{8'h12}}}) begin
            bad++; $display("FAIL invalid got vld=%b upd=%b data=%h",
                            wr_l2req_valid, wr_update_l2_data, wr_data);
        end
    endtask

    task automatic test_store_sync();
        // Core1/strand2 reserves 0x20, then store_syncs the same line.
        drive(1'b1, 2'd1, 2'd2, OP_LOAD_SYNC, 26'h20, 1'b1, 1'b0, '0, '0, '0, '0, 2'd1);
        step();
        total++;
        if ({wr_store_sync_success, wr_update_l2_data} !== 2'b00) begin
            bad++; $display("FAIL load_sync got ss=%b upd=%b exp 0/0",
                            wr_store_sync_success, wr_update_l2_data);
        end
        drive(1'b1, 2'd1, 2'd2, OP_STORE_SYNC, 26'h20, 1'b1, 1'b0, '0, '0,
              {64{8'h5A}}, {64{1'b1}}, 2'd1);
        step();
        total++;
        if ({wr_store_sync_success, wr_update_l2_data} !== {SYNC_EN, SYNC_EN}) begin
            bad++; $display("FAIL sync_first got ss=%b upd=%b exp %b/%b",
                            wr_store_sync_success, wr_update_l2_data, SYNC_EN, SYNC_EN);
        end
        total++;
        if (wr_data !== (SYNC_EN ? {64{8'h5A}} : 512'd0)) begin
            bad++; $display("FAIL sync_first_data got=%h", wr_data);
        end
        // The successful store consumed the reservation.
        drive(1'b1, 2'd1, 2'd2, OP_STORE_SYNC, 26'h20, 1'b1, 1'b0, '0, '0,
              {64{8'h5A}}, {64{1'b1}}, 2'd1);
        step();
        total++;
        if ({wr_store_sync_success, wr_update_l2_data, wr_data} !== {2'b00, 512'd0}) begin
            bad++; $display("FAIL sync_repeat got ss=%b upd=%b exp 0/0",
                            wr_store_sync_success, wr_update_l2_data);
        end
    endtask

    task automatic test_sync_kill();
        // A plain store from another strand kills core0/strand0's reservation.
        drive(1'b1, 2'd0, 2'd0, OP_LOAD_SYNC, 26'h30, 1'b1, 1'b0, '0, '0, '0, '0, 2'd0);
        step();
        drive(1'b1, 2'd1, 2'd3, OP_STORE, 26'h30, 1'b1, 1'b0, '0, '0,
              {64{8'h01}}, {64{1'b1}}, 2'd0);
        step();
        total++;
        if (wr_update_l2_data !== 1'b1) begin
            bad++; $display("FAIL kill_store got upd=%b exp 1", wr_update_l2_data);
        end
        drive(1'b1, 2'd0, 2'd0, OP_STORE_SYNC, 26'h30, 1'b1, 1'b0, '0, '0,
              {64{8'h02}}, {64{1'b1}}, 2'd0);
        step();
        total++;
        if ({wr_store_sync_success, wr_update_l2_data} !== 2'b00) begin
            bad++; $display("FAIL sync_killed got ss=%b upd=%b exp 0/0",
                            wr_store_sync_success, wr_update_l2_data);
        end
        // Reservation belongs to one strand only.
        drive(1'b1, 2'd0, 2'd1, OP_LOAD_SYNC, 26'h50, 1'b1, 1'b0, '0, '0, '0, '0, 2'd0);
        step();
        drive(1'b1, 2'd0, 2'd2, OP_STORE_SYNC, 26'h50, 1'b1, 1'b0, '0, '0,
              {64{8'h02}}, {64{1'b1}}, 2'd0);
        step();
        total++;
        if ({wr_store_sync_success, wr_update_l2_data} !== 2'b00) begin
            bad++; $display("FAIL sync_wrong_strand got ss=%b upd=%b exp 0/0",
                            wr_store_sync_success, wr_update_l2_data);
        end
        // Owner's store_sync to a different line fails too; then the right
        // line succeeds (enabled build) since the entry is still intact.
        drive(1'b1, 2'd0, 2'd1, OP_STORE_SYNC, 26'h51, 1'b1, 1'b0, '0, '0,
              {64{8'h02}}, {64{1'b1}}, 2'd0);
        step();
        total++;
        if ({wr_store_sync_success, wr_update_l2_data} !== 2'b00) begin
            bad++; $display("FAIL sync_wrong_addr got ss=%b upd=%b exp 0/0",
                            wr_store_sync_success, wr_update_l2_data);
        end
        drive(1'b1, 2'd0, 2'd1, OP_STORE_SYNC, 26'h50, 1'b1, 1'b0, '0, '0,
              {64{8'h02}}, {64{1'b1}}, 2'd0);
        step();
        total++;
        if ({wr_store_sync_success, wr_update_l2_data} !== {SYNC_EN, SYNC_EN}) begin
            bad++; $display("FAIL sync_owner got ss=%b upd=%b exp %b/%b",
                            wr_store_sync_success, wr_update_l2_data, SYNC_EN, SYNC_EN);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 2'd0, 2'd1, OP_STORE, 26'h60, 1'b1, 1'b0, '0, {64{8'h00}},
              {64{8'hC3}}, 64'h00000000000000FF, 2'd1);
        step();
        total++;
        if ({wr_data, wr_update_l2_address} !== {{56{8'h00}}, {8{8'hC3}}, 26'h60}) begin
            bad++; $display("FAIL b2b_0 got addr=%h data=%h", wr_update_l2_address, wr_data);
        end
        drive(1'b1, 2'd1, 2'd0, OP_LOAD, 26'h61, 1'b1, 1'b0, '0, {64{8'h81}},
              {64{8'hC3}}, {64{1'b1}}, 2'd2);
        step();
        total++;
        if ({wr_data, wr_update_l2_data, wr_update_l2_address, wr_l2req_core} !==
            {{64{8'h81}}, 1'b0, 26'h61, 2'd1}) begin
            bad++; $display("FAIL b2b_1 got upd=%b addr=%h data=%h",
                            wr_update_l2_data, wr_update_l2_address, wr_data);
        end
        idle();
        step();
        total++;
        if ({wr_l2req_valid, wr_update_l2_data} !== 2'b00) begin
            bad++; $display("FAIL b2b_idle got vld=%b upd=%b exp 0/0",
                            wr_l2req_valid, wr_update_l2_data);
        end
    endtask

    task automatic test_reset_mid();
        // Reserve, then drop reset asynchronously while a store is in flight.
        drive(1'b1, 2'd1, 2'd1, OP_LOAD_SYNC, 26'h70, 1'b1, 1'b0, '0, '0, '0, '0, 2'd0);
        step();
        drive(1'b1, 2'd1, 2'd1, OP_STORE, 26'h71, 1'b1, 1'b0, '0, {64{8'h0F}},
              {64{8'hF0}}, {64{1'b1}}, 2'd3);
        step();
        reset_n = 1'b0;
        #1;
        total++;
        if ({wr_l2req_valid, wr_update_l2_data, wr_data} !== '0) begin
            bad++; $display("FAIL mid_reset got vld=%b upd=%b", wr_l2req_valid, wr_update_l2_data);
        end
        idle();
        step();
        reset_n = 1'b1;
        step();
        total++;
        if ({wr_l2req_valid, wr_update_l2_data} !== 2'b00) begin
            bad++; $display("FAIL no_replay got vld=%b upd=%b exp 0/0",
                            wr_l2req_valid, wr_update_l2_data);
        end
        // The reservation taken before reset is gone.
        drive(1'b1, 2'd1, 2'd1, OP_STORE_SYNC, 26'h70, 1'b1, 1'b0, '0, '0,
              {64{8'h33}}, {64{1'b1}}, 2'd0);
        step();
        total++;
        if ({wr_store_sync_success, wr_update_l2_data} !== 2'b00) begin
            bad++; $display("FAIL resv_cleared got ss=%b upd=%b exp 0/0",
                            wr_store_sync_success, wr_update_l2_data);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        test_reset();
        drive(1'b1, 2'd0, 2'd0, OP_LOAD, 26'h1, 1'b1, 1'b0, '0, '0, '0, '0, 2'd0);
        step();
        test_passthrough();
        test_store_merge();
        test_fill();
        test_miss_and_flush();
        test_store_sync();
        test_sync_kill();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l2_cache_write.md
Name: l2_cache_write

Overview:
- L2 pipeline write stage: sits between the L2 read stage (rd_*) and the L2 response stage (wr_*).
- Selects the line source: fill data from the system-memory path, or the cache SRAM read.
- Merges store data into the line under a byte mask and drives the L2 data SRAM write port.
- Tracks per-strand load_sync reservations to produce the store_sync success flag.
- All wr_* outputs are registered; latency is one cycle, and there is no stall.

Parameters:
- ADDR_WIDTH, 26, line address width (byte address bits 31:6).

Ports:
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- rd_l2req_valid  in  1  request valid
- rd_l2req_core  in  2  issuing core
- rd_l2req_unit  in  2  issuing unit
- rd_l2req_strand  in  2  issuing strand
- rd_l2req_op  in  3  op: LOAD=0, STORE=1, FLUSH=2, INVALIDATE=3, LOAD_SYNC=4, STORE_SYNC=5
- rd_l2req_way  in  2  L1 way
- rd_l2req_address  in  ADDR_WIDTH  line address
- rd_l2req_data  in  512  store data
- rd_l2req_mask  in  64  byte enables
- rd_hit_l2_way  in  2  L2 way that hit/filled
- rd_cache_hit  in  1  L2 tag hit
- rd_has_sm_data  in  1  line comes from memory fill
- rd_sm_data  in  512  fill line
- rd_cache_mem_result  in  512  SRAM read line
- rd_l1_has_line_core0  in  1  directory: core0 holds line
- rd_dir_l1_way_core0  in  2  core0 L1 way
- rd_l1_has_line_core1  in  1  directory: core1 holds line
- rd_dir_l1_way_core1  in  2  core1 L1 way
- wr_l2req_valid/core/unit/strand/op/way  out  1/2/2/2/3/2  registered pass-through
- wr_data  out  512  final line contents
- wr_l1_has_line_core0, wr_dir_l1_way_core0, wr_l1_has_line_core1, wr_dir_l1_way_core1  out  1/2/1/2  pass-through
- wr_cache_hit, wr_has_sm_data  out  1/1  pass-through
- wr_store_sync_success  out  1  store_sync succeeded
- wr_update_l2_data  out  1  SRAM data write enable
- wr_update_l2_way  out  2  SRAM way
- wr_update_l2_address  out  ADDR_WIDTH  SRAM line address

Behaviour:
- Reset: every output is 0; all reservations are invalid. Asserting reset mid-request drops the request; nothing is replayed.
- Every posedge: every wr_* output loads from the current rd_* inputs; no enables.
- serviced = rd_l2req_valid && (rd_cache_hit || rd_has_sm_data).
- old_line = rd_has_sm_data ? rd_sm_data : rd_cache_mem_result.
- Byte i (0..63) = bits [511-8i : 504-8i]. mask[63-i] enables byte i, so mask bit 63 maps to bits 511:504.
- sync_ok: serviced && op==STORE_SYNC && resv[idx].valid && resv[idx].addr==rd_l2req_address, where idx = core*4+strand (8 entries).
- commit_store = serviced && (op==STORE || sync_ok).
- wr_data: the merged line (mask ? store byte : old byte) when commit_store; otherwise old_line.
- Mask 0 with commit_store: wr_data equals old_line, and the SRAM write still fires.
- wr_update_l2_data = serviced && (rd_has_sm_data || commit_store). Way = rd_hit_l2_way; address = rd_l2req_address.
- wr_store_sync_success = sync_ok. It is 0 for every other op and for misses.
- Reservations (update at the clock edge):
  - serviced LOAD_SYNC: resv[idx] <= {1, address}, overwriting any older entry.
  - commit_store: clear every entry whose addr == address, including the issuer's own entry.
  - STORE_SYNC failure or miss: no reservation change.
  - A miss (not serviced) never touches reservations or the SRAM. It is still passed through with wr_l2req_valid=1; the response stage drops it.
- FLUSH/INVALIDATE: pass-through only; no SRAM write unless rd_has_sm_data.

Optional Feature:
- Macro: L2_STORE_SYNC_EN.
- Defined: reservation table and behaviour exactly as above.
- Undefined: no table; sync_ok is constant 0. STORE_SYNC never writes and wr_store_sync_success is always 0. LOAD_SYNC behaves as LOAD.

Test Plan:
- Reset held low with random rd_* inputs -> all outputs 0. After release, the first valid request appears on wr_* exactly 1 cycle later.
- STORE hit, address 0x10, old line all 0x00, data all 0xFF, mask 0xF000000000000001 -> wr_data: bits 511:480 = 0xFFFFFFFF, bits 7:0 = 0xFF, rest 0; wr_update_l2_data=1.
- Core1/strand2 LOAD_SYNC 0x20 hit, then STORE_SYNC 0x20 same strand -> wr_store_sync_success=1 and data written. A repeat STORE_SYNC -> 0, no write.
- Core0/strand0 LOAD_SYNC 0x30, core1/strand3 STORE to 0x30, then core0/strand0 STORE_SYNC 0x30 -> success 0, wr_update_l2_data=0.
- LOAD miss with rd_has_sm_data=1, fill pattern 0xA5 -> wr_data all 0xA5, wr_update_l2_data=1, way = rd_hit_l2_way.
- Macro undefined: LOAD_SYNC then STORE_SYNC to the same line -> success 0, no SRAM write.
